// File: rtl/candidate_best_selector.sv
// candidate_best_selector: scans candidate bank slots and reports the highest Q-value at or above a threshold.
module candidate_best_selector #(
   parameter int WORD_WIDTH = 16,
   parameter int INDEX_W    = 4,
   parameter int MAX_SLOTS  = 8,
   parameter int SLOT_W     = 3
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic [SLOT_W:0]       cand_count,
   input  logic [WORD_WIDTH-1:0] min_q,
   output logic [INDEX_W-1:0]    index,
   input  logic [WORD_WIDTH-1:0] data_in,
   output logic                  busy,
   output logic                  done,
   output logic                  found,
   output logic [WORD_WIDTH-1:0] best_q,
   output logic [SLOT_W-1:0]     best_slot,
   output logic [INDEX_W-1:0]    best_index
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t                state_q, state_d;
   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic [SLOT_W:0]       count_q, count_d;
   logic [WORD_WIDTH-1:0] thr_q, thr_d;
   logic [WORD_WIDTH-1:0] best_q_q, best_q_d;
   logic [SLOT_W-1:0]     best_slot_q, best_slot_d;
   logic                  found_q, found_d;
   logic                  accept;
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      count_d     = count_q;
      thr_d       = thr_q;
      best_q_d    = best_q_q;
      best_slot_d = best_slot_q;
      found_d     = found_q;
      accept      = (data_in >= thr_q) && (!found_q || data_in > best_q_q);
      case (state_q)
         IDLE: if (start) begin
            count_d     = cand_count > (SLOT_W+1)'(MAX_SLOTS) ? (SLOT_W+1)'(MAX_SLOTS) : cand_count;
            thr_d       = min_q;
            found_d     = 1'b0;
            best_q_d    = '0;
            best_slot_d = '0;
            slot_d      = '0;
            state_d     = count_d == '0 ? DONE : SCAN;
         end
         SCAN: begin
            if (accept) begin
               found_d     = 1'b1;
               best_q_d    = data_in;
               best_slot_d = slot_q;
            end
            if ({1'b0, slot_q} == count_q - (SLOT_W+1)'(1)) state_d = DONE;
            else slot_d = slot_q + SLOT_W'(1);
         end
         DONE: begin
            state_d = IDLE;
            slot_d  = '0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         count_q     <= '0;
         thr_q       <= '0;
         best_q_q    <= '0;
         best_slot_q <= '0;
         found_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         count_q     <= count_d;
         thr_q       <= thr_d;
         best_q_q    <= best_q_d;
         best_slot_q <= best_slot_d;
         found_q     <= found_d;
      end
   end
   assign index      = state_q == SCAN ? INDEX_W'({slot_q, 1'b0}) : '0;
   assign busy       = state_q != IDLE;
   assign done       = state_q == DONE;
   assign found      = found_q;
   assign best_q     = best_q_q;
   assign best_slot  = best_slot_q;
   assign best_index = INDEX_W'({best_slot_q, 1'b0});
endmodule

// File: doc/candidate_best_selector.md
Name: candidate_best_selector

Overview:
- Downstream consumer of the candidate memory bank. That bank stores 16-bit candidate words (Q-values) as byte pairs at even byte indices and has a combinational read port.
- On a start pulse, this block drives the bank's read index and scans the valid candidate slots, one word per clock.
- It reports the highest Q-value at or above a threshold, plus its slot and byte index, so the routing stage can pick the next hop.
- It never writes the bank.

Parameters:
- WORD_WIDTH, 16, width of one candidate word and of the Q-value.
- INDEX_W, 4, width of the bank byte index.
- MAX_SLOTS, 8, number of 16-bit slots addressable, equal to 2^INDEX_W / 2.
- SLOT_W, 3, width of the slot number, equal to log2(MAX_SLOTS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a scan; ignored while busy=1.
- cand_count  in  SLOT_W+1  number of valid slots, 0..MAX_SLOTS; sampled on accepted start.
- min_q  in  WORD_WIDTH  unsigned acceptance threshold; sampled on accepted start.
- index  out  INDEX_W  byte index driven to the bank read port; always 2*slot.
- data_in  in  WORD_WIDTH  bank read data {memory[index], memory[index+1]}, valid in the same cycle as index.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse when the result is valid.
- found  out  1  at least one slot satisfied q >= min_q in the last scan.
- best_q  out  WORD_WIDTH  best Q-value of the last scan; 0 if found=0.
- best_slot  out  SLOT_W  slot number of best_q; 0 if found=0.
- best_index  out  INDEX_W  byte index of best_q, equal to 2*best_slot.

Behaviour:
- Reset (nrst=0, asynchronous):
  - State returns to IDLE.
  - Outputs: index=0, busy=0, done=0, found=0, best_q=0, best_slot=0, best_index=0.
  - All internal registers cleared.
- States: IDLE, SCAN, DONE.
- IDLE:
  - index holds 0; busy=0.
  - start=1 latches cand_count and min_q, clears found/best_*, and sets slot=0.
  - If the latched count is 0, go to DONE; otherwise go to SCAN.
- SCAN, one slot per cycle:
  - index = 2*slot is registered, so data_in is stable for the whole cycle.
  - At each rising edge, evaluate data_in as unsigned.
  - The word is accepted when data_in >= min_q_latched and either found=0 or data_in > best_q (strict).
  - On acceptance, update best_q, best_slot and best_index, and set found=1.
  - Ties therefore keep the lowest slot.
  - If slot == count-1, go to DONE; otherwise increment slot.
  - Latency for N slots: N SCAN cycles plus 1 DONE cycle, so done asserts N+1 cycles after the start edge.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then return to IDLE with busy=0.
  - best_*/found hold until the next accepted start or reset.
- Index wrap: slot never exceeds MAX_SLOTS-1.
  - cand_count > MAX_SLOTS is clamped to MAX_SLOTS at latch time.
  - index never wraps past 2*(MAX_SLOTS-1).
- start while busy=1 (SCAN or DONE) is ignored, and no queued restart occurs.
- start in the same cycle DONE returns to IDLE is ignored; it must arrive while in IDLE.
- Bank writes during a scan are not blocked. The word read is whatever data_in shows at the sampling edge; the upstream writer is responsible for not writing while busy=1.
- Reset mid-scan aborts immediately: busy=0, no done pulse, results cleared.
- Arithmetic: unsigned comparisons only; no accumulation, so there is no overflow.

Test Plan:
- Bank slots 0..3 = 0x0010, 0x0200, 0x0150, 0x0200; cand_count=4; min_q=0; pulse start.
  - Required: index sequence 0,2,4,6; done 5 cycles after start; found=1, best_q=0x0200, best_slot=1, best_index=2 (tie keeps lowest slot).
- Same data, min_q=0x0300.
  - Required: done after 5 cycles; found=0, best_q=0, best_slot=0.
- cand_count=0, start.
  - Required: no SCAN cycles; done 1 cycle after start; found=0; index stays 0.
- cand_count=12 (greater than MAX_SLOTS=8), slot 7 = 0xFFFF, others 0x0001.
  - Required: 8 SCAN cycles; index max 14; best_slot=7, best_index=14, best_q=0xFFFF.
- start re-pulsed on cycle 2 of a 4-slot scan.
  - Required: the scan is not restarted; a single done pulse arrives at cycle 5.
- nrst asserted on cycle 2 of a scan.
  - Required: outputs immediately 0, no done pulse.
  - After release, a fresh start completes normally with correct result.
